// File: rtl/expr_pkg.sv
// Shared token/ASCII constants, FSM states and the token encoder for the expr checker path.
// Pure definitions; no timing or flow control of its own.
package expr_pkg;
  localparam logic [3:0] TOK_PLUS = 4'd10;
  localparam logic [3:0] TOK_MUL  = 4'd11;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_BAD   = 8'h3F;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  function automatic logic [7:0] encode(input logic [3:0] t);
    logic [7:0] c;
    if (t < TOK_PLUS)      c = CH_ZERO + {4'h0, t};
    else if (t == TOK_PLUS) c = CH_PLUS;
    else if (t == TOK_MUL)  c = CH_MUL;
    else                    c = CH_BAD;
    return c;
  endfunction
endpackage

// File: rtl/tok_fifo.sv
// DEPTH x 4-bit token buffer: write is dropped when full, read is ignored when empty.
// Registered pointers/count; rd_dat/nxt_dat expose the head and the entry behind it.
module tok_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [3:0]        wr_dat,
  input  logic              rd_en,
  output logic [3:0]        rd_dat,
  output logic [3:0]        nxt_dat,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [3:0]        mem_q [DEPTH];
  logic [3:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_dat  = mem_q[rd_ptr_q];
  assign nxt_dat = mem_q[rd_ptr_q + ADDR_W'(1)];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_wr && !do_rd)      count_d = count_q + (ADDR_W+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (ADDR_W+1)'(1);
  end

  // Storage needs no clear: pointers and count alone define what is buffered.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/expr_tx.sv
// Buffers tokens, streams them as ASCII one char per accepted beat, and reports the expected verdict.
// First char the cycle after start; out holds while ready=0; done pulses the cycle after the last beat.
module expr_tx
  import expr_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic [3:0] tok,
  output logic       full,
  input  logic       start,
  output logic       busy,
  input  logic       ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done,
  output logic       well_formed
);
  state_t          state_q, state_d;
  logic            seq_ok_q, seq_ok_d, last_dig_q, last_dig_d;
  logic [7:0]      out_q, out_d;
  logic            out_valid_q, out_valid_d, done_q, done_d;
  logic            wf_q, wf_d, busy_q, busy_d;
  logic            wr_en, rd_en, fifo_clr, ff_full, ff_empty, tok_dig, tok_op;
  logic [3:0]      rd_dat, nxt_dat;
  logic [ADDR_W:0] count;

  tok_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk), .clr(fifo_clr), .wr_en(wr_en), .wr_dat(tok), .rd_en(rd_en),
    .rd_dat(rd_dat), .nxt_dat(nxt_dat), .count(count), .full(ff_full), .empty(ff_empty)
  );

  always_comb begin
    tok_dig     = (tok < TOK_PLUS);
    tok_op      = (tok == TOK_PLUS) || (tok == TOK_MUL);
    state_d     = state_q;
    seq_ok_d    = seq_ok_q;
    last_dig_d  = last_dig_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    wf_d        = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    fifo_clr    = clr;
    case (state_q)
      IDLE: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        if (push && !ff_full) begin
          wr_en      = 1'b1;
          seq_ok_d   = ff_empty ? tok_dig : (seq_ok_q && (last_dig_q ? tok_op : tok_dig));
          last_dig_d = tok_dig;
        end
        if (start) begin
          if (wr_en || !ff_empty) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            // A token pushed alongside start into an empty buffer is itself the head.
            out_d       = encode(ff_empty ? tok : rd_dat);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (ready) begin
          rd_en = 1'b1;
          if (count == (ADDR_W+1)'(1)) begin
            state_d     = DONE;
            out_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            wf_d        = seq_ok_q && last_dig_q;
          end else begin
            out_d = encode(nxt_dat);
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        fifo_clr   = 1'b1;
        seq_ok_d   = 1'b0;
        last_dig_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      seq_ok_q    <= 1'b0;
      last_dig_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      wf_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_ok_q    <= seq_ok_d;
      last_dig_q  <= last_dig_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      wf_q        <= wf_d;
      busy_q      <= busy_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign well_formed = wf_q;
  assign busy        = busy_q;
  assign full        = ff_full;
endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: a queue-level model of the token stream and verdict,
// checked by a per-cycle monitor plus hand-computed literal expectations.
module tb_expr_tx;
  logic       clk = 1'b0;
  logic       clr = 1'b1, push = 1'b0, start = 1'b0, ready = 1'b1;
  logic [3:0] tok = 4'd0;
  logic       full, busy, out_valid, done, well_formed;
  logic [7:0] out;

  expr_tx #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .push(push), .tok(tok), .full(full), .start(start),
    .busy(busy), .ready(ready), .out(out), .out_valid(out_valid), .done(done),
    .well_formed(well_formed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [3:0] model_q[$];
  logic [7:0] exp_chars[$];
  logic [7:0] got[$];
  bit exp_wf, active = 1'b0, done_hit = 1'b0, last_wf;
  int idx = 0, lat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_enc(input logic [3:0] t);
    string s = "0123456789+*????";
    return s[t];
  endfunction

  // Well formed: odd length, digits at even positions, operators at odd positions.
  function automatic bit m_wf();
    if (model_q.size() % 2 == 0) return 1'b0;
    foreach (model_q[i]) begin
      if (i % 2 == 0 && model_q[i] > 4'd9) return 1'b0;
      if (i % 2 == 1 && !(model_q[i] == 4'd10 || model_q[i] == 4'd11)) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (active && idx < exp_chars.size()) begin
        chk("char", out, exp_chars[idx]);
        if (ready) begin
          got.push_back(out);
          idx++;
        end
      end else chk("stray_out_valid", out_valid, 0);
    end
    if (done) begin
      if (active) begin
        chk("well_formed", well_formed, exp_wf);
        chk("char_count", idx, exp_chars.size());
        last_wf  = well_formed;
        done_hit = 1'b1;
        active   = 1'b0;
      end else chk("stray_done", done, 0);
    end
  end

  task automatic do_push(input logic [3:0] t);
    push = 1'b1; tok = t;
    @(posedge clk); #1;
    push = 1'b0;
    if (model_q.size() < 16) model_q.push_back(t);
  endtask

  task automatic arm();
    exp_chars.delete(); got.delete();
    foreach (model_q[i]) exp_chars.push_back(m_enc(model_q[i]));
    exp_wf = m_wf();
    model_q.delete();
    idx = 0; done_hit = 1'b0; active = 1'b1;
  endtask

  task automatic stream(input logic [7:0] rpat, input bit push_en, input logic [3:0] ptok, output int l);
    if (push_en && model_q.size() < 16) model_q.push_back(ptok);
    arm();
    push = push_en; tok = ptok; start = 1'b1; ready = rpat[0];
    @(posedge clk); #1;
    push = 1'b0; start = 1'b0;
    chk("busy_after_start", busy, 1);
    l = 0;
    while (!done_hit && l < 300) begin
      ready = rpat[(l + 1) % 8];
      @(posedge clk); #1;
      l++;
    end
    if (!done_hit) chk("done_timeout", 0, 1);
    chk("busy_after_done", busy, 0);
    ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_wf", well_formed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    clr = 1'b0;
    @(posedge clk); #1;

    // "1+1"
    do_push(4'd1); do_push(4'd10); do_push(4'd1);
    stream(8'hFF, 1'b0, 4'd0, lat);
    chk("t1_lat", lat, 4);
    chk("t1_n", got.size(), 3);
    chk("t1_c0", got[0], 8'h31);
    chk("t1_c1", got[1], 8'h2B);
    chk("t1_c2", got[2], 8'h31);
    chk("t1_wf", last_wf, 1);

    // "2*3+" ends on an operator
    do_push(4'd2); do_push(4'd11); do_push(4'd3); do_push(4'd10);
    stream(8'hFF, 1'b0, 4'd0, lat);
    chk("t2_n", got.size(), 4);
    chk("t2_wf", last_wf, 0);

    // "55" has no operator between digits
    do_push(4'd5); do_push(4'd5);
    stream(8'hFF, 1'b0, 4'd0, lat);
    chk("t3_wf", last_wf, 0);

    // illegal token
    do_push(4'd12);
    stream(8'hFF, 1'b0, 4'd0, lat);
    chk("t4_c0", got[0], 8'h3F);
    chk("t4_wf", last_wf, 0);

    // empty start
    stream(8'hFF, 1'b0, 4'd0, lat);
    chk("t5_lat", lat, 1);
    chk("t5_n", got.size(), 0);
    chk("t5_wf", last_wf, 0);

    // fill to capacity, drop a 17th push, stream; twice to wrap the pointers
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 16; i++) do_push((i % 2 == 0) ? 4'd10 : 4'd7);
      chk("t6_full", full, 1);
      do_push(4'd7);
      chk("t6_full_after_drop", full, 1);
      stream(8'hFF, 1'b0, 4'd0, lat);
      chk("t6_lat", lat, 17);
      chk("t6_n", got.size(), 16);
      chk("t6_last", got[15], 8'h37);
      chk("t6_full_cleared", full, 0);
    end

    // "4*6+8" with ready stalls 1,0,0,1,...
    do_push(4'd4); do_push(4'd11); do_push(4'd6); do_push(4'd10); do_push(4'd8);
    stream(8'b1001_1001, 1'b0, 4'd0, lat);
    chk("t7_n", got.size(), 5);
    chk("t7_c1", got[1], 8'h2A);
    chk("t7_c4", got[4], 8'h38);
    chk("t7_wf", last_wf, 1);

    // clr after two of five characters
    do_push(4'd1); do_push(4'd10); do_push(4'd2); do_push(4'd10); do_push(4'd3);
    arm();
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    active = 1'b0;
    chk("t8_out_valid", out_valid, 0);
    chk("t8_busy", busy, 0);
    chk("t8_sent", idx, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("t8_no_done", done_hit, 0);

    // fresh "9", pushed in the same cycle as start
    stream(8'hFF, 1'b1, 4'd9, lat);
    chk("t9_n", got.size(), 1);
    chk("t9_c0", got[0], 8'h39);
    chk("t9_wf", last_wf, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
